// File: rtl/bingo_turn_ctrl.sv
// bingo_turn_ctrl: turn sequencer between the keyboard entry path and the
// inter-board link. It validates local BCD entries and peer binary calls, owns
// whose turn it is, sends local calls with a valid/ready handshake and emits
// one mark strobe per accepted number.
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   start, first           game start pulse; first=1 -> local side calls first
//   game_over              level from board logic; ends the game
//   display_num            BCD entry {tens,ones}
//   enter_pulse            enter strobe for display_num
//   peer_valid, peer_num   peer call strobe and binary number
//   tx_ready               link accepts tx_num this cycle
//   tx_valid, tx_num       local call towards the peer, held until tx_ready
//   mark_valid, mark_num   one-cycle mark strobe and accepted number
//   my_turn                high while waiting for a local call
//   err_pulse              one-cycle strobe for a rejected call
//   busy                   high while a game is in progress
//
// Optional feature: define TURN_TIMEOUT_EN to auto-call the lowest unused
// number after TIMEOUT_CYC cycles of local inactivity.
module bingo_turn_ctrl #(
  parameter int unsigned MAX_NUM     = 25,
  parameter int unsigned NUM_W       = 5,
  parameter logic [31:0] TIMEOUT_CYC = 32'd500_000_000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             first,
  input  logic             game_over,
  input  logic [7:0]       display_num,
  input  logic             enter_pulse,
  input  logic             peer_valid,
  input  logic [NUM_W-1:0] peer_num,
  input  logic             tx_ready,
  output logic             tx_valid,
  output logic [NUM_W-1:0] tx_num,
  output logic             mark_valid,
  output logic [NUM_W-1:0] mark_num,
  output logic             my_turn,
  output logic             err_pulse,
  output logic             busy
);

  localparam int unsigned VAL_W = 7;
  localparam int unsigned CNT_W = $clog2(MAX_NUM + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOCAL,
    S_SEND,
    S_PEER,
    S_DONE
  } state_e;

  state_e               state_q, state_d;
  logic [MAX_NUM:1]     used_q, used_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 tx_valid_q, tx_valid_d;
  logic [NUM_W-1:0]     tx_num_q, tx_num_d;
  logic                 mark_valid_q, mark_valid_d;
  logic [NUM_W-1:0]     mark_num_q, mark_num_d;
  logic                 my_turn_q, my_turn_d;
  logic                 err_pulse_q, err_pulse_d;
  logic                 busy_q, busy_d;

  logic [VAL_W-1:0]     entry_val_c;
  logic                 entry_ok_c;
  logic [VAL_W-1:0]     peer_val_c;
  logic                 peer_ok_c;
  logic                 take_c;
  logic                 take_local_c;
  logic [VAL_W-1:0]     take_val_c;

`ifdef TURN_TIMEOUT_EN
  logic [31:0]          timer_q, timer_d;
  logic [VAL_W-1:0]     low_val_c;
  logic                 expire_c;
`else
  logic                 unused_timeout_c;
  assign unused_timeout_c = ^TIMEOUT_CYC;
`endif

  // True when v is in 1..MAX_NUM and not yet called; 0 and out-of-range values
  // never match a bitmap position and so read as illegal.
  function automatic logic num_ok(input logic [MAX_NUM:1] used,
                                  input logic [VAL_W-1:0] v);
    logic ok;
    ok = 1'b0;
    for (int unsigned i = 1; i <= MAX_NUM; i++) begin
      if (v == VAL_W'(i)) ok = !used[i];
    end
    return ok;
  endfunction

  // Next-state and registered-output logic.
  always_comb begin
    state_d      = state_q;
    used_d       = used_q;
    count_d      = count_q;
    tx_valid_d   = tx_valid_q;
    tx_num_d     = tx_num_q;
    mark_valid_d = 1'b0;
    mark_num_d   = mark_num_q;
    err_pulse_d  = 1'b0;
    take_c       = 1'b0;
    take_local_c = 1'b0;
    take_val_c   = '0;

    entry_val_c = VAL_W'(display_num[7:4]) * VAL_W'(10) + VAL_W'(display_num[3:0]);
    entry_ok_c  = (display_num[7:4] <= 4'd9) && (display_num[3:0] <= 4'd9) &&
                  num_ok(used_q, entry_val_c);
    peer_val_c  = VAL_W'(peer_num);
    peer_ok_c   = num_ok(used_q, peer_val_c);

`ifdef TURN_TIMEOUT_EN
    // Lowest unused number: scan downwards so the smallest hit wins.
    low_val_c = '0;
    for (int unsigned i = MAX_NUM; i >= 1; i--) begin
      if (!used_q[i]) low_val_c = VAL_W'(i);
    end
    expire_c = (timer_q >= TIMEOUT_CYC - 32'd1);
`endif

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          used_d  = '0;
          count_d = '0;
          state_d = first ? S_LOCAL : S_PEER;
        end
      end
      S_LOCAL: begin
        // game_over drops any call arriving in the same cycle.
        if (game_over) begin
          state_d = S_DONE;
        end else if (enter_pulse) begin
          if (entry_ok_c) begin
            take_c       = 1'b1;
            take_local_c = 1'b1;
            take_val_c   = entry_val_c;
          end else begin
            err_pulse_d = 1'b1;
          end
        end
`ifdef TURN_TIMEOUT_EN
        else if (expire_c) begin
          take_c       = 1'b1;
          take_local_c = 1'b1;
          take_val_c   = low_val_c;
        end
`endif
      end
      S_SEND: begin
        // The transfer always completes; game_over only redirects the exit.
        if (tx_ready) begin
          tx_valid_d = 1'b0;
          state_d    = (count_q == CNT_W'(MAX_NUM) || game_over) ? S_DONE : S_PEER;
        end
      end
      S_PEER: begin
        if (game_over) begin
          state_d = S_DONE;
        end else if (peer_valid) begin
          if (peer_ok_c) begin
            take_c     = 1'b1;
            take_val_c = peer_val_c;
          end else begin
            err_pulse_d = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Accept a call: record it, mark it, and either send it or hand the turn back.
    if (take_c) begin
      for (int unsigned i = 1; i <= MAX_NUM; i++) begin
        if (take_val_c == VAL_W'(i)) used_d[i] = 1'b1;
      end
      count_d      = count_q + CNT_W'(1);
      mark_valid_d = 1'b1;
      mark_num_d   = NUM_W'(take_val_c);
      if (take_local_c) begin
        tx_valid_d = 1'b1;
        tx_num_d   = NUM_W'(take_val_c);
        state_d    = S_SEND;
      end else begin
        state_d = (count_d == CNT_W'(MAX_NUM)) ? S_DONE : S_LOCAL;
      end
    end

`ifdef TURN_TIMEOUT_EN
    // Timer runs only while staying in LOCAL_TURN; any entry restarts it at 0.
    timer_d = (state_q == S_LOCAL && state_d == S_LOCAL) ? timer_q + 32'd1 : 32'd0;
`endif

    my_turn_d = (state_d == S_LOCAL);
    busy_d    = (state_d == S_LOCAL) || (state_d == S_SEND) || (state_d == S_PEER);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      used_q       <= '0;
      count_q      <= '0;
      tx_valid_q   <= 1'b0;
      tx_num_q     <= '0;
      mark_valid_q <= 1'b0;
      mark_num_q   <= '0;
      my_turn_q    <= 1'b0;
      err_pulse_q  <= 1'b0;
      busy_q       <= 1'b0;
`ifdef TURN_TIMEOUT_EN
      timer_q      <= '0;
`endif
    end else begin
      state_q      <= state_d;
      used_q       <= used_d;
      count_q      <= count_d;
      tx_valid_q   <= tx_valid_d;
      tx_num_q     <= tx_num_d;
      mark_valid_q <= mark_valid_d;
      mark_num_q   <= mark_num_d;
      my_turn_q    <= my_turn_d;
      err_pulse_q  <= err_pulse_d;
      busy_q       <= busy_d;
`ifdef TURN_TIMEOUT_EN
      timer_q      <= timer_d;
`endif
    end
  end

  assign tx_valid   = tx_valid_q;
  assign tx_num     = tx_num_q;
  assign mark_valid = mark_valid_q;
  assign mark_num   = mark_num_q;
  assign my_turn    = my_turn_q;
  assign err_pulse  = err_pulse_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_bingo_turn_ctrl.sv
// Testbench for bingo_turn_ctrl: directed scenarios followed by randomized
// play, every cycle compared against a game-level reference model.
module tb_bingo_turn_ctrl;

  localparam int MAXN = 25;
`ifdef TURN_TIMEOUT_EN
  localparam int TO = 16;
  localparam logic [31:0] TB_TO_CYC = 32'd16;
`else
  localparam logic [31:0] TB_TO_CYC = 32'd500_000_000;
`endif

  // Game phases of the reference model.
  localparam int P_IDLE = 0, P_LOCAL = 1, P_SEND = 2, P_PEER = 3, P_DONE = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0, first = 1'b0, game_over = 1'b0;
  logic [7:0] display_num = 8'h00;
  logic       enter_pulse = 1'b0, peer_valid = 1'b0, tx_ready = 1'b0;
  logic [4:0] peer_num = 5'd0;
  logic       tx_valid, mark_valid, my_turn, err_pulse, busy;
  logic [4:0] tx_num, mark_num;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state.
  int ph;
  bit used_m [0:127];
  int cnt_m, tmr_m;
  int e_tx_valid, e_tx_num, e_mark_valid, e_mark_num, e_my_turn, e_err, e_busy;

  always #5 clk = ~clk;

  bingo_turn_ctrl #(.TIMEOUT_CYC(TB_TO_CYC)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .first(first), .game_over(game_over),
    .display_num(display_num), .enter_pulse(enter_pulse), .peer_valid(peer_valid),
    .peer_num(peer_num), .tx_ready(tx_ready), .tx_valid(tx_valid), .tx_num(tx_num),
    .mark_valid(mark_valid), .mark_num(mark_num), .my_turn(my_turn),
    .err_pulse(err_pulse), .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0d expected %0d", tag, $time, got, exp);
    end
  endtask

  task automatic check_all();
    chk("tx_valid",   32'(tx_valid),   32'(e_tx_valid));
    chk("tx_num",     32'(tx_num),     32'(e_tx_num));
    chk("mark_valid", 32'(mark_valid), 32'(e_mark_valid));
    chk("mark_num",   32'(mark_num),   32'(e_mark_num));
    chk("my_turn",    32'(my_turn),    32'(e_my_turn));
    chk("err_pulse",  32'(err_pulse),  32'(e_err));
    chk("busy",       32'(busy),       32'(e_busy));
  endtask

  function automatic bit legal(int v);
    return v >= 1 && v <= MAXN && !used_m[v];
  endfunction

  task automatic model_reset();
    ph = P_IDLE;
    foreach (used_m[k]) used_m[k] = 1'b0;
    cnt_m = 0; tmr_m = 0;
    e_tx_valid = 0; e_tx_num = 0; e_mark_valid = 0; e_mark_num = 0;
    e_my_turn = 0; e_err = 0; e_busy = 0;
  endtask

  // One clock edge of the game rules, applied to the inputs currently driven.
  task automatic model_step();
    int  old_ph, tens, ones, v, tv;
    bit  took, from_local;
    old_ph = ph; took = 0; from_local = 0; tv = 0;
    e_mark_valid = 0; e_err = 0;
    case (ph)
      P_IDLE, P_DONE:
        if (start) begin
          foreach (used_m[k]) used_m[k] = 1'b0;
          cnt_m = 0;
          ph = first ? P_LOCAL : P_PEER;
        end
      P_LOCAL:
        if (game_over) ph = P_DONE;
        else if (enter_pulse) begin
          tens = int'(display_num) / 16;
          ones = int'(display_num) % 16;
          v = tens * 10 + ones;
          if (tens < 10 && ones < 10 && legal(v)) begin took = 1; from_local = 1; tv = v; end
          else e_err = 1;
        end
`ifdef TURN_TIMEOUT_EN
        else if (tmr_m >= TO - 1) begin
          for (int k = MAXN; k >= 1; k--) if (!used_m[k]) tv = k;
          took = 1; from_local = 1;
        end
`endif
      P_SEND:
        if (tx_ready) begin
          e_tx_valid = 0;
          ph = (cnt_m == MAXN || game_over) ? P_DONE : P_PEER;
        end
      P_PEER:
        if (game_over) ph = P_DONE;
        else if (peer_valid) begin
          if (legal(int'(peer_num))) begin took = 1; tv = int'(peer_num); end
          else e_err = 1;
        end
      default: ;
    endcase
    if (took) begin
      used_m[tv] = 1'b1;
      cnt_m++;
      e_mark_valid = 1; e_mark_num = tv;
      if (from_local) begin
        e_tx_valid = 1; e_tx_num = tv; ph = P_SEND;
      end else begin
        ph = (cnt_m == MAXN) ? P_DONE : P_LOCAL;
      end
    end
    tmr_m = (old_ph == P_LOCAL && ph == P_LOCAL) ? tmr_m + 1 : 0;
    e_my_turn = (ph == P_LOCAL);
    e_busy = (ph == P_LOCAL || ph == P_SEND || ph == P_PEER);
  endtask

  // Called at a falling edge: drive inputs, let one rising edge pass, check.
  task automatic cyc(input bit st, input bit fi, input bit go, input bit en,
                     input logic [7:0] dn, input bit pv, input logic [4:0] pn,
                     input bit tr);
    start = st; first = fi; game_over = go; enter_pulse = en; display_num = dn;
    peer_valid = pv; peer_num = pn; tx_ready = tr;
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic idle_cyc(input bit tr);
    cyc(0, 0, 0, 0, 8'h00, 0, 5'd0, tr);
  endtask

  // Asynchronous reset in the middle of the low clock phase.
  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    start = 0; first = 0; game_over = 0; enter_pulse = 0; display_num = 8'h00;
    peer_valid = 0; peer_num = 5'd0; tx_ready = 0;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic logic [7:0] bcd(int v);
    return 8'((v / 10) * 16 + (v % 10));
  endfunction

  function automatic int pick_unused();
    int v;
    v = int'($urandom_range(1, MAXN));
    for (int t = 0; t < 40 && used_m[v]; t++) v = int'($urandom_range(1, MAXN));
    return v;
  endfunction

  initial begin
    int v;
    logic [7:0] dn;
    logic [4:0] pn;
    model_reset();
    @(negedge clk);
    check_all();
    @(negedge clk);
    rst_n = 1'b1;

    // Local call 7, link stalls for three cycles, then peer turn.
    cyc(1, 1, 0, 0, 8'h00, 0, 5'd0, 0);
    cyc(0, 0, 0, 1, 8'h07, 0, 5'd0, 0);
    repeat (3) idle_cyc(0);
    idle_cyc(1);
    idle_cyc(0);
    // Enter during the peer turn is ignored; peer calls 12.
    cyc(0, 0, 0, 1, 8'h09, 0, 5'd0, 0);
    cyc(0, 0, 0, 0, 8'h00, 1, 5'd12, 0);
    // Rejected local entries, peer strobe ignored.
    cyc(0, 0, 0, 1, 8'h00, 0, 5'd0, 0);
    cyc(0, 0, 0, 1, 8'h26, 0, 5'd0, 0);
    cyc(0, 0, 0, 1, 8'h1A, 0, 5'd0, 0);
    cyc(0, 0, 0, 1, 8'h07, 1, 5'd3, 0);
    // game_over beats a valid entry; restart clears the bitmap.
    cyc(0, 0, 1, 1, 8'h05, 0, 5'd0, 0);
    idle_cyc(0);
    cyc(1, 1, 0, 0, 8'h00, 0, 5'd0, 0);
    cyc(0, 0, 0, 1, 8'h05, 0, 5'd0, 0);
    idle_cyc(0);
    // Reset while a transfer is pending.
    do_reset();

    // Full game of 25 alternating calls ending in DONE.
    cyc(1, 1, 0, 0, 8'h00, 0, 5'd0, 0);
    for (int k = 1; k <= MAXN; k++) begin
      if (k % 2 == 1) begin
        cyc(0, 0, 0, 1, bcd(k), 0, 5'd0, 0);
        idle_cyc(1);
      end else begin
        cyc(0, 0, 0, 0, 8'h00, 1, 5'(k), 0);
      end
    end
    idle_cyc(0);

`ifdef TURN_TIMEOUT_EN
    // Timeout auto-call after 1 and 2 are used.
    cyc(1, 1, 0, 0, 8'h00, 0, 5'd0, 0);
    cyc(0, 0, 0, 1, 8'h01, 0, 5'd0, 0);
    idle_cyc(1);
    cyc(0, 0, 0, 0, 8'h00, 1, 5'd2, 0);
    repeat (TO + 2) idle_cyc(0);
    idle_cyc(1);
`endif

    // Randomized play.
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 799) == 0) begin
        do_reset();
        continue;
      end
      dn = 8'($urandom);
      if ($urandom_range(0, 9) < 6) begin
        v = pick_unused();
        dn = bcd(v);
      end
      pn = 5'($urandom);
      if ($urandom_range(0, 9) < 6) pn = 5'(pick_unused());
      cyc((ph == P_IDLE || ph == P_DONE) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 15) == 0),
          1'($urandom),
          $urandom_range(0, 149) == 0,
          $urandom_range(0, 2) == 0, dn,
          $urandom_range(0, 2) == 0, pn,
          1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
